// File: rtl/playback_transport_ctrl.sv
// playback_transport_ctrl
//   Transport and elapsed-time display controller for the audio player.
//   Synchronises and debounces the previous/next buttons and synchronises the pause switch.
//   Keeps the current track index, which wraps around at both ends.
//   Counts elapsed mm:ss per track, saturating at 99:59, and drives four 7-segment digits.
// Ports
//   clk_clk, reset_reset_n      : clock, asynchronous active-low reset
//   anterior_btn, siguiente_btn : raw active-low buttons (asynchronous)
//   pausa_sw                    : raw pause switch, 1 = paused (asynchronous)
//   track_end                   : 1-cycle end-of-track pulse from the audio path
//   track_idx                   : current track index
//   track_change                : 1-cycle pulse, audio path reloads track_idx from its start
//   playing                     : high while the FSM is in PLAY
//   min1/min2, seg1/seg2        : minutes tens/units, seconds tens/units, {g,f,e,d,c,b,a}
module playback_transport_ctrl #(
   parameter int unsigned CLK_HZ         = 50000000,
   parameter int unsigned NUM_TRACKS     = 8,
   parameter int unsigned TRACK_W        = 3,
   parameter int unsigned DEBOUNCE_CYC   = 1000000,
   parameter int unsigned RESTART_SEC    = 3,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic               anterior_btn,
   input  logic               siguiente_btn,
   input  logic               pausa_sw,
   input  logic               track_end,
   output logic [TRACK_W-1:0] track_idx,
   output logic               track_change,
   output logic               playing,
   output logic [6:0]         min1,
   output logic [6:0]         min2,
   output logic [6:0]         seg1,
   output logic [6:0]         seg2
);

   localparam int unsigned PresW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned DebW  = $clog2(DEBOUNCE_CYC + 1);

   typedef enum logic [1:0] {StPlay, StPause, StChg} state_e;

   // Active-high segment pattern for a BCD digit, then output polarity applied.
   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      logic [6:0] on;
      case (d)
         4'd0:    on = 7'h3F;
         4'd1:    on = 7'h06;
         4'd2:    on = 7'h5B;
         4'd3:    on = 7'h4F;
         4'd4:    on = 7'h66;
         4'd5:    on = 7'h6D;
         4'd6:    on = 7'h7D;
         4'd7:    on = 7'h07;
         4'd8:    on = 7'h7F;
         4'd9:    on = 7'h6F;
         default: on = 7'h00;
      endcase
      return SEG_ACTIVE_LOW ? ~on : on;
   endfunction

   // Bit 0 = anterior, bit 1 = siguiente. Buttons are active-low, so released = 1.
   logic [1:0]            btn_s1_q, btn_s2_q;
   logic [1:0]            deb_q, deb_d;
   logic [1:0]            arm_q, arm_d;
   logic [1:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;
   logic [1:0]            press;
   logic [1:0]            warm_q, warm_d;
   logic                  warm;
   logic                  pausa_s1_q, pausa_s2_q;

   state_e                state_q, state_d;
   logic [TRACK_W-1:0]    idx_q, idx_d;
   logic [PresW-1:0]      presc_q, presc_d;
   logic [3:0]            min_t_q, min_t_d, min_u_q, min_u_d;
   logic [3:0]            sec_t_q, sec_t_d, sec_u_q, sec_u_d;
   logic [6:0]            min1_q, min2_q, seg1_q, seg2_q;

   logic                  next_ev, prev_ev, restart, tick, sat;
   logic [6:0]            sec_bin;

   // The synchronizer needs two cycles after reset to hold real input samples.
   assign warm   = warm_q[1];
   assign warm_d = warm ? warm_q : warm_q + 2'd1;

   // A button is only armed once it has been seen released after reset, so a
   // button held through reset release never produces a press.
   always_comb begin
      deb_d     = deb_q;
      arm_d     = arm_q;
      deb_cnt_d = '0;
      press     = '0;
      for (int i = 0; i < 2; i++) begin
         if (btn_s2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DebW'(DEBOUNCE_CYC - 1)) begin
               deb_d[i] = btn_s2_q[i];
               press[i] = arm_q[i] & ~btn_s2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
            end
         end
         if (warm && btn_s2_q[i] && deb_q[i]) begin
            arm_d[i] = 1'b1;
         end
      end
   end

   assign sec_bin = 7'(sec_t_q) * 7'd10 + 7'(sec_u_q);
   assign restart = (min_t_q != 4'd0) || (min_u_q != 4'd0) || (32'(sec_bin) >= RESTART_SEC);
   assign next_ev = press[1] | (track_end & (state_q == StPlay));
   assign prev_ev = press[0];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         StPlay, StPause: begin
            // Simultaneous next and prev cancel each other out.
            if (next_ev ^ prev_ev) begin
               state_d = StChg;
               if (next_ev) begin
                  idx_d = (idx_q == TRACK_W'(NUM_TRACKS - 1)) ? '0 : idx_q + TRACK_W'(1);
               end else if (!restart) begin
                  idx_d = (idx_q == '0) ? TRACK_W'(NUM_TRACKS - 1) : idx_q - TRACK_W'(1);
               end
            end else begin
               state_d = pausa_s2_q ? StPause : StPlay;
            end
         end
         StChg:   state_d = pausa_s2_q ? StPause : StPlay;
         default: state_d = StPause;
      endcase
   end

   assign sat = (min_t_q == 4'd9) && (min_u_q == 4'd9) && (sec_t_q == 4'd5) && (sec_u_q == 4'd9);

   always_comb begin
      presc_d = presc_q;
      min_t_d = min_t_q;
      min_u_d = min_u_q;
      sec_t_d = sec_t_q;
      sec_u_d = sec_u_q;
      tick    = 1'b0;
      if (state_q == StChg) begin
         presc_d = '0;
         min_t_d = 4'd0;
         min_u_d = 4'd0;
         sec_t_d = 4'd0;
         sec_u_d = 4'd0;
      end else if (state_q == StPlay) begin
         if (presc_q == PresW'(CLK_HZ - 1)) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + PresW'(1);
         end
      end
      if (tick && !sat) begin
         if (sec_u_q != 4'd9) begin
            sec_u_d = sec_u_q + 4'd1;
         end else begin
            sec_u_d = 4'd0;
            if (sec_t_q != 4'd5) begin
               sec_t_d = sec_t_q + 4'd1;
            end else begin
               sec_t_d = 4'd0;
               if (min_u_q != 4'd9) begin
                  min_u_d = min_u_q + 4'd1;
               end else begin
                  min_u_d = 4'd0;
                  min_t_d = min_t_q + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         btn_s1_q   <= 2'b11;
         btn_s2_q   <= 2'b11;
         deb_q      <= 2'b11;
         arm_q      <= 2'b00;
         deb_cnt_q  <= '0;
         warm_q     <= 2'd0;
         pausa_s1_q <= 1'b0;
         pausa_s2_q <= 1'b0;
         state_q    <= StPause;
         idx_q      <= '0;
         presc_q    <= '0;
         min_t_q    <= 4'd0;
         min_u_q    <= 4'd0;
         sec_t_q    <= 4'd0;
         sec_u_q    <= 4'd0;
         min1_q     <= seg_enc(4'd0);
         min2_q     <= seg_enc(4'd0);
         seg1_q     <= seg_enc(4'd0);
         seg2_q     <= seg_enc(4'd0);
      end else begin
         btn_s1_q   <= {siguiente_btn, anterior_btn};
         btn_s2_q   <= btn_s1_q;
         deb_q      <= deb_d;
         arm_q      <= arm_d;
         deb_cnt_q  <= deb_cnt_d;
         warm_q     <= warm_d;
         pausa_s1_q <= pausa_sw;
         pausa_s2_q <= pausa_s1_q;
         state_q    <= state_d;
         idx_q      <= idx_d;
         presc_q    <= presc_d;
         min_t_q    <= min_t_d;
         min_u_q    <= min_u_d;
         sec_t_q    <= sec_t_d;
         sec_u_q    <= sec_u_d;
         min1_q     <= seg_enc(min_t_q);
         min2_q     <= seg_enc(min_u_q);
         seg1_q     <= seg_enc(sec_t_q);
         seg2_q     <= seg_enc(sec_u_q);
      end
   end

   assign track_idx    = idx_q;
   assign track_change = (state_q == StChg);
   assign playing      = (state_q == StPlay);
   assign min1         = min1_q;
   assign min2         = min2_q;
   assign seg1         = seg1_q;
   assign seg2         = seg2_q;

endmodule

// File: tb/tb_playback_transport_ctrl.sv
module tb_playback_transport_ctrl;

   localparam int unsigned CLK_HZ = 10;
   localparam int unsigned NUM    = 3;
   localparam int unsigned TW     = 2;
   localparam int unsigned DEB    = 4;
   localparam int unsigned RS     = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          anterior, siguiente, pausa, track_end;
   logic [TW-1:0] track_idx;
   logic          track_change, playing;
   logic [6:0]    min1, min2, seg1, seg2;

   int checks = 0;
   int errors = 0;
   int chg_cnt = 0;
   int sb_q[$];
   int model_idx = 0;

   playback_transport_ctrl #(
      .CLK_HZ        (CLK_HZ),
      .NUM_TRACKS    (NUM),
      .TRACK_W       (TW),
      .DEBOUNCE_CYC  (DEB),
      .RESTART_SEC   (RS),
      .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk_clk      (clk),
      .reset_reset_n(rst_n),
      .anterior_btn (anterior),
      .siguiente_btn(siguiente),
      .pausa_sw     (pausa),
      .track_end    (track_end),
      .track_idx    (track_idx),
      .track_change (track_change),
      .playing      (playing),
      .min1         (min1),
      .min2         (min2),
      .seg1         (seg1),
      .seg2         (seg2)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Active-low DE-series digit patterns {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic int inc_idx(input int i);
      return (i == NUM - 1) ? 0 : i + 1;
   endfunction

   function automatic int dec_idx(input int i);
      return (i == 0) ? NUM - 1 : i - 1;
   endfunction

   task automatic check_time(input string tag, input int mm, input int ss);
      check_eq({tag, "_min1"}, min1, seg_of(mm / 10));
      check_eq({tag, "_min2"}, min2, seg_of(mm % 10));
      check_eq({tag, "_seg1"}, seg1, seg_of(ss / 10));
      check_eq({tag, "_seg2"}, seg2, seg_of(ss % 10));
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_idx"}, track_idx, 0);
      check_eq({tag, "_playing"}, playing, 0);
      check_eq({tag, "_chg"}, track_change, 0);
      check_time(tag, 0, 0);
   endtask

   // Bounce (1 low, 1 high), 8 low, 10 high. Optional track_end in the
   // same cycle as the debounced press.
   task automatic press(input bit sig, input bit ant, input bit te);
      logic lvl;
      for (int i = 0; i < 20; i++) begin
         lvl       = !(i == 0 || (i >= 2 && i < 10));
         siguiente = sig ? lvl : 1'b1;
         anterior  = ant ? lvl : 1'b1;
         track_end = te && (i == 7);
         @(negedge clk);
      end
   endtask

   // Scoreboard consumer: each track_change pulse pops the expected index.
   always begin
      @(negedge clk);
      if (rst_n && track_change) begin
         chg_cnt++;
         check_eq("sb_pending", sb_q.size() > 0, 1);
         if (sb_q.size() > 0) check_eq("chg_idx", track_idx, sb_q.pop_front());
         @(negedge clk);
         check_eq("chg_width", track_change, 0);
         @(negedge clk);
         check_time("chg_time", 0, 0);
      end
   end

   initial begin
      int n;
      int c0;
      logic [6:0] prev;
      rst_n     = 1'b1;
      anterior  = 1'b1;
      siguiente = 1'b1;
      pausa     = 1'b0;
      track_end = 1'b0;
      #1 rst_n = 1'b0;
      #2 check_reset("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Free-running play from reset.
      repeat (3) @(negedge clk);
      check_eq("t1_playing", playing, 1);
      repeat (22) @(negedge clk);
      check_eq("t1_seg2", seg2, seg_of(2));
      check_eq("t1_idx", track_idx, 0);
      check_eq("t1_nochg", chg_cnt, 0);

      // Three debounced siguiente presses.
      for (int k = 0; k < 3; k++) begin
         model_idx = inc_idx(model_idx);
         sb_q.push_back(model_idx);
         press(1'b1, 1'b0, 1'b0);
      end
      check_eq("t2_count", chg_cnt, 3);
      check_eq("t2_idx", track_idx, 0);

      // anterior late in the track restarts; early in the track goes back.
      repeat (50) @(negedge clk);
      sb_q.push_back(model_idx);
      press(1'b0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      model_idx = dec_idx(model_idx);
      sb_q.push_back(model_idx);
      press(1'b0, 1'b1, 1'b0);
      check_eq("t3_idx", track_idx, 2);

      // track_end advances in PLAY.
      model_idx = inc_idx(model_idx);
      sb_q.push_back(model_idx);
      track_end = 1'b1;
      @(negedge clk);
      track_end = 1'b0;
      repeat (5) @(negedge clk);
      prev = seg2;
      n = 0;
      while (seg2 == prev && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_eq("t4_tick", seg2, seg_of(1));

      // Pause: time frozen, track_end ignored, prescaler held.
      pausa = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("t4_paused", playing, 0);
      c0 = chg_cnt;
      track_end = 1'b1;
      @(negedge clk);
      track_end = 1'b0;
      repeat (50) @(negedge clk);
      check_time("t4_frozen", 0, 1);
      check_eq("t4_te_ignored", chg_cnt, c0);
      pausa = 1'b0;
      prev = seg2;
      n = 0;
      while (seg2 == prev && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_eq("t4_resume_cyc", n, 10);
      check_eq("t4_resume_seg2", seg2, seg_of(2));

      // Simultaneous next and prev cancel; siguiente + track_end advance once.
      c0 = chg_cnt;
      press(1'b1, 1'b1, 1'b0);
      check_eq("t5_both_nochg", chg_cnt, c0);
      check_eq("t5_both_idx", track_idx, model_idx);
      model_idx = inc_idx(model_idx);
      sb_q.push_back(model_idx);
      press(1'b1, 1'b0, 1'b1);
      check_eq("t5_te_sig_cnt", chg_cnt, c0 + 1);
      check_eq("t5_te_sig_idx", track_idx, model_idx);

      // Button held through reset release gives no event.
      @(negedge clk);
      rst_n     = 1'b0;
      siguiente = 1'b0;
      model_idx = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      c0 = chg_cnt;
      repeat (20) @(negedge clk);
      siguiente = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("t6_held_nochg", chg_cnt, c0);
      check_eq("t6_held_idx", track_idx, 0);

      // Run to saturation.
      repeat (60100) @(negedge clk);
      check_time("t6_sat", 99, 59);
      repeat (30) @(negedge clk);
      check_time("t6_hold", 99, 59);

      // Async reset mid-count.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check_eq("t6_counting", seg2, seg_of(1));
      #2 rst_n = 1'b0;
      #1 check_reset("t6_async");
      repeat (2) @(negedge clk);
      check_eq("sb_drained", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
